// File: rtl/cobra_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the CYBERcobra program loader.
// The loader takes the slave modport; the byte source / memory side takes master.
interface cobra_prog_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;

    modport master (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );
endinterface

// File: rtl/cobra_prog_loader.sv
// CYBERcobra program loader: length header + little-endian words into instruction memory,
// core held in reset until the image is in. Define LOADER_CHECKSUM_EN for the XOR trailer byte.
module cobra_prog_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cobra_prog_loader_if.slave bus,
    input  logic               reload_i,
    output logic               core_rst_o,
    output logic               done_o,
    output logic               error_o,
    output logic [15:0]        words_o
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    state_t            state_q;
    logic              ready_q;
    logic              core_rst_q;
    logic              done_q;
    logic              error_q;
    logic [15:0]       words_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [31:0]       word_p0;
    logic [1:0]        bcnt_p0;
    logic              mem_we_p1;
    logic [ADDR_W-1:0] mem_addr_p1;
    logic [31:0]       mem_wdata_p1;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic accept;
    assign accept = bus.byte_valid_i && ready_q && !reload_i;

    function automatic logic hdr_too_big(input logic [15:0] n);
        return int'(n) > MAX_WORDS;
    endfunction

    // Bytes arrive least significant first, so each new byte enters at the top.
    function automatic logic [31:0] shift_in(input logic [31:0] w, input logic [7:0] b);
        return {b, w[31:8]};
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] idx);
        return ADDR_W'({idx, 2'b00});
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_LEN_LO;
            ready_q      <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_p0      <= '0;
            bcnt_p0      <= '0;
            mem_we_p1    <= 1'b0;
            mem_addr_p1  <= '0;
            mem_wdata_p1 <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else if (reload_i) begin
            state_q    <= S_LEN_LO;
            ready_q    <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            word_p0    <= '0;
            bcnt_p0    <= '0;
            mem_we_p1  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            mem_we_p1 <= 1'b0;
            case (state_q)
                S_LEN_LO: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        len_lo_q <= bus.byte_i;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        len_q <= {bus.byte_i, len_lo_q};
                        if (hdr_too_big({bus.byte_i, len_lo_q})) begin
                            state_q <= S_ERR;
                            ready_q <= 1'b0;
                            error_q <= 1'b1;
                        end else if ({bus.byte_i, len_lo_q} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= S_CSUM;
`else
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                // Assembly stage (p0) feeds the one-cycle write strobe stage (p1).
                S_DATA: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        word_p0 <= shift_in(word_p0, bus.byte_i);
                        bcnt_p0 <= bcnt_p0 + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ bus.byte_i;
`endif
                        if (bcnt_p0 == 2'd3) begin
                            mem_we_p1    <= 1'b1;
                            mem_wdata_p1 <= shift_in(word_p0, bus.byte_i);
                            mem_addr_p1  <= word_addr(words_q);
                            words_q      <= words_q + 16'd1;
                            if (words_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
                                ready_q <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (bus.byte_i == csum_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                // Release lags entry to DONE by a cycle so the final strobe lands first.
                S_DONE: begin
                    ready_q    <= 1'b0;
                    core_rst_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                S_ERR: begin
                    ready_q    <= 1'b0;
                    core_rst_q <= 1'b1;
                    error_q    <= 1'b1;
                end
                default: begin
                    state_q <= S_LEN_LO;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.mem_we_o     = mem_we_p1;
    assign bus.mem_addr_o   = mem_addr_p1;
    assign bus.mem_wdata_o  = mem_wdata_p1;
    assign core_rst_o       = core_rst_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign words_o          = words_q;

endmodule

// File: doc/cobra_prog_loader.md
Name: cobra_prog_loader

Overview:
- Program-loader front end for the CYBERcobra core: the writer side of the instruction memory that the core reads.
- Accepts a byte stream over a valid/ready handshake (from UART RX or a debug bridge) and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory write port and holds the core in reset until the image is fully loaded.

Parameters:
- MAX_WORDS, 1024, instruction memory capacity in words; a larger length header is an error.
- ADDR_W, 32, width of mem_addr_o (byte address).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- byte_i  in  8  incoming stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader can accept a byte; transfer occurs when valid && ready on a rising clk_i
- reload_i  in  1  single-cycle request to restart loading
- mem_we_o  out  1  instruction memory write strobe, one cycle per word
- mem_addr_o  out  ADDR_W  byte address of the word = word_index*4
- mem_wdata_o  out  32  assembled word
- core_rst_o  out  1  hold CYBERcobra in reset (1 = hold)
- done_o  out  1  image loaded, core released
- error_o  out  1  load aborted on a bad header (or bad checksum)
- words_o  out  16  number of words written so far

Behaviour:
- Reset values:
  - core_rst_o=1, byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, error_o=0, words_o=0.
  - State LEN_LO.
- States:
  - LEN_LO, LEN_HI: 16-bit little-endian word count N.
  - DATA: 4*N bytes; byte k of a word goes to bits [8k+7:8k].
  - DONE.
  - ERR.
- byte_ready_o=1 in LEN_LO, LEN_HI and DATA; 0 in DONE and ERR. Stalls on byte_valid_i=0 are unlimited, and no state is lost.
- Header transitions:
  - LEN_LO -> LEN_HI on accept.
  - LEN_HI on accept:
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - Otherwise -> DATA.
- Word write:
  - On acceptance of the 4th byte of a word, the next cycle drives mem_we_o=1 for exactly one cycle, with mem_wdata_o = assembled word and mem_addr_o = words_o*4 (pre-increment value).
  - words_o increments in that same cycle.
  - Back-to-back bytes are accepted during the write cycle (no bubble).
- DATA -> DONE when the last word's write strobe is issued.
- In DONE, core_rst_o drops to 0 in the cycle after the final mem_we_o, so the core never fetches a partially written word.
- DONE: core_rst_o=0, done_o=1; incoming bytes are ignored (ready low).
- ERR: core_rst_o=1, error_o=1; mem_we_o is never asserted again.
- reload_i (any state, including mid-DATA):
  - Next state LEN_LO; core_rst_o=1.
  - done_o, error_o, words_o and the partial word are cleared.
  - A byte presented in the same cycle as reload_i is not accepted.
- rst_i mid-load: immediate return to reset values; a pending write strobe is dropped.
- mem_addr_o wraps naturally; it cannot exceed (MAX_WORDS-1)*4 because of the header check.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, the loader expects one trailer byte equal to the XOR of all 4*N data bytes (state CSUM; 0x00 when N==0).
  - Match -> DONE.
  - Mismatch -> ERR, with core_rst_o held at 1; words already written stay in memory.
  - The DONE transition and core release happen only after the trailer is accepted.
- Undefined: no trailer byte and no CSUM state; DATA goes directly to DONE.

Test Plan:
- Stream 02 00, then 13 00 00 00, then 37 12 00 00 -> mem_we_o pulses writing addr 0x0 data 0x00000013 and addr 0x4 data 0x00001237. words_o=2, done_o=1, core_rst_o falls one cycle after the second strobe.
- Header 00 00 -> no mem_we_o, DONE within 1 cycle of the second byte, core_rst_o=0.
- Header 01 04 (N=1025) with MAX_WORDS=1024 -> ERR, error_o=1, byte_ready_o=0, core_rst_o=1, no writes.
- byte_valid_i toggled randomly with 1-5 idle cycles between bytes of a 3-word image -> same memory contents and addresses as the continuous stream.
- reload_i asserted after 6 of 8 data bytes, then a full 1-word image AA BB CC DD is sent -> single write of 0xDDCCBBAA at addr 0x0, words_o=1, no write from the aborted image.
- LOADER_CHECKSUM_EN defined, image 01 00 11 22 33 44:
  - Trailer 44 -> DONE.
  - Trailer 45 -> ERR with core_rst_o=1.
